// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and default frame geometry.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned SIZE_DATA_DEF   = 8;
    localparam int unsigned OVER_SAMPLE_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Transmitter handshake bundle: baud tick, show-ahead FIFO head/pop, serial line and status.
interface uart_transmitter_if
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_DATA = SIZE_DATA_DEF
);

    logic                 i_stick;
    logic                 i_tx_en;
    logic                 i_fifo_empty;
    logic [SIZE_DATA-1:0] i_tx_data;
    logic                 o_tx_rd;
    logic                 o_tx_serial;
    logic                 o_tx_busy;
    logic                 o_tx_done;

    modport master (
        output i_stick,
        output i_tx_en,
        output i_fifo_empty,
        output i_tx_data,
        input  o_tx_rd,
        input  o_tx_serial,
        input  o_tx_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_stick,
        input  i_tx_en,
        input  i_fifo_empty,
        input  i_tx_data,
        output o_tx_rd,
        output o_tx_serial,
        output o_tx_busy,
        output o_tx_done
    );

endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: pops a word from a show-ahead FIFO and sends start, LSB-first data and
// stop bits, each bit lasting OVER_SAMPLE baud ticks.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_DATA   = SIZE_DATA_DEF,
    parameter int unsigned OVER_SAMPLE = OVER_SAMPLE_DEF
) (
    input logic               i_clk,
    input logic               i_rst,
    uart_transmitter_if.slave tx_if
);

    localparam int unsigned TickW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
    localparam int unsigned BitW  = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

    uart_state_e          state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [SIZE_DATA-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 busy;

    logic load;
    logic tick_end;
    logic last_bit;

    // Reset also gates the pop so an aborted or held-off block never consumes a FIFO word.
    assign load     = (state_q == StIdle) && tx_if.i_tx_en && !tx_if.i_fifo_empty && !i_rst;
    assign tick_end = tx_if.i_stick && (tick_q == TickW'(OVER_SAMPLE - 1));
    assign last_bit = (bit_q == BitW'(SIZE_DATA - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (load) state_d = StStart;
            StStart: if (tick_end) state_d = StData;
            StData:  if (tick_end && last_bit) state_d = StStop;
            StStop:  if (tick_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = tx_if.i_tx_data;
                end
            end
            StStart, StStop: begin
                if (tick_end) begin
                    tick_d = '0;
                    bit_d  = '0;
                end else if (tx_if.i_stick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StData: begin
                if (tick_end) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    // Clear rather than wrap when leaving DATA.
                    bit_d   = last_bit ? '0 : bit_q + 1'b1;
                end else if (tx_if.i_stick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                tick_d = '0;
                bit_d  = '0;
            end
        endcase
    end

    // Line level is registered from the next state so it changes on the same edge as the state.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
        done_d = (state_q == StStop) && tick_end;
        busy   = (state_q != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign tx_if.o_tx_rd     = load;
    assign tx_if.o_tx_serial = serial_q;
    assign tx_if.o_tx_busy   = busy;
    assign tx_if.o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter: frame bit levels sampled mid-bit by
// baud-tick count, done timing, back-to-back gap, enable drop and mid-frame reset.
module tb_uart_transmitter;

    logic clk;
    logic rst;

    uart_transmitter_if #(.SIZE_DATA(8)) tx_if ();

    uart_transmitter #(
        .SIZE_DATA  (8),
        .OVER_SAMPLE(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .tx_if(tx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fifo_q[$];
    bit         stick_hold = 1'b0;
    int         div_cnt    = 0;

    int rd_cnt     = 0;
    int done_cnt   = 0;
    int done_at    = 0;
    int since_load = 0;
    int idle_run   = 0;
    int gap        = 0;
    int idle_viol  = 0;
    bit mon_idle   = 1'b0;

    int exp_rd   = 0;
    int exp_done = 0;

    // Baud tick source (one pulse every 3 clocks, or held high) and show-ahead FIFO view.
    always @(negedge clk) begin
        if (stick_hold) begin
            tx_if.i_stick = 1'b1;
        end else begin
            tx_if.i_stick = (div_cnt == 2);
            div_cnt = (div_cnt == 2) ? 0 : div_cnt + 1;
        end
        tx_if.i_fifo_empty = (fifo_q.size() == 0);
        tx_if.i_tx_data    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Event counters; since_load counts ticks seen after the cycle that popped the FIFO.
    always @(posedge clk) begin
        if (tx_if.o_tx_rd === 1'b1) begin
            rd_cnt     <= rd_cnt + 1;
            since_load <= 0;
            gap        <= idle_run + 1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end else if (tx_if.i_stick === 1'b1) begin
            since_load <= since_load + 1;
        end
        idle_run <= (tx_if.o_tx_busy === 1'b1) ? 0 : idle_run + 1;
        if (tx_if.o_tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_at  <= since_load;
        end
        if (mon_idle && (tx_if.o_tx_serial !== 1'b1 || tx_if.o_tx_rd !== 1'b0))
            idle_viol <= idle_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_since(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (since_load == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rd(input int target);
        for (int i = 0; i < 2000; i++) begin
            if (rd_cnt == target) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt == target) break;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input logic [7:0] data, input int drop_k);
        logic [9:0] frame;
        bit         ok;
        frame = {1'b1, data, 1'b0};
        exp_rd++;
        exp_done++;
        wait_rd(exp_rd);
        chk($sformatf("load_%02h", data), rd_cnt, exp_rd);
        for (int k = 0; k < 10; k++) begin
            wait_since(16 * k + 8, ok);
            chk($sformatf("bit%0d_%02h", k, data), {ok, tx_if.o_tx_serial}, {1'b1, frame[k]});
            if (k == 5) chk($sformatf("busy_%02h", data), tx_if.o_tx_busy, 1'b1);
            if (k == drop_k) tx_if.i_tx_en = 1'b0;
        end
        wait_done(exp_done);
        chk($sformatf("done_cnt_%02h", data), done_cnt, exp_done);
        chk($sformatf("done_at_%02h", data), done_at, 160);
    endtask

    initial begin
        bit ok;
        rst                = 1'b1;
        tx_if.i_tx_en      = 1'b0;
        tx_if.i_stick      = 1'b0;
        tx_if.i_fifo_empty = 1'b1;
        tx_if.i_tx_data    = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_serial", tx_if.o_tx_serial, 1'b1);
        chk("rst_busy", tx_if.o_tx_busy, 1'b0);
        chk("rst_done", tx_if.o_tx_done, 1'b0);
        chk("rst_rd", tx_if.o_tx_rd, 1'b0);

        // Enabled but FIFO empty: line must stay idle with no pops.
        rst           = 1'b0;
        tx_if.i_tx_en = 1'b1;
        mon_idle      = 1'b1;
        repeat (2000) @(negedge clk);
        mon_idle = 1'b0;
        chk("empty_idle_viol", idle_viol, 0);
        chk("empty_no_rd", rd_cnt, 0);

        // Reset held with data waiting: no pop until reset is released.
        rst = 1'b1;
        fifo_q.push_back(8'h55);
        repeat (4) @(negedge clk);
        chk("rst_holds_rd", rd_cnt, 0);
        chk("rst_rd_low", tx_if.o_tx_rd, 1'b0);
        rst = 1'b0;
        check_frame(8'h55, -1);

        // Back-to-back frames.
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        check_frame(8'hA5, -1);
        check_frame(8'h3C, -1);
        chk("b2b_gap", gap, 1);

        // Enable dropped during data bit 3: frame completes, next word stays in the FIFO.
        fifo_q.push_back(8'hF0);
        fifo_q.push_back(8'h11);
        check_frame(8'hF0, 4);
        repeat (300) @(negedge clk);
        chk("drop_no_rd", rd_cnt, exp_rd);
        chk("drop_fifo_left", fifo_q.size(), 1);
        chk("drop_idle_busy", tx_if.o_tx_busy, 1'b0);
        chk("drop_idle_serial", tx_if.o_tx_serial, 1'b1);
        fifo_q.delete();
        repeat (2) @(negedge clk);
        tx_if.i_tx_en = 1'b1;

        // One-cycle reset during data bit 4 aborts the frame without a done pulse.
        fifo_q.push_back(8'h5A);
        exp_rd++;
        wait_rd(exp_rd);
        chk("abort_load", rd_cnt, exp_rd);
        wait_since(16 * 5 + 4, ok);
        chk("abort_reach", ok, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_serial", tx_if.o_tx_serial, 1'b1);
        chk("abort_busy", tx_if.o_tx_busy, 1'b0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_no_done", done_cnt, exp_done);
        chk("abort_no_rd", rd_cnt, exp_rd);
        fifo_q.push_back(8'h00);
        check_frame(8'h00, -1);

        // Tick held high: each bit is 16 clocks, done 160 clocks after START.
        stick_hold = 1'b1;
        repeat (2) @(negedge clk);
        fifo_q.push_back(8'h81);
        check_frame(8'h81, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk is the clock, i_rst is the reset, and there is no other clock or reset.
REQ-002 SIZE_DATA, default 8, SHALL set the number of data bits per frame.
REQ-003 OVER_SAMPLE, default 16, SHALL set the number of i_stick ticks per bit period.
REQ-004 i_clk  input  1  system clock (50 MHz).
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_stick  input  1  baud tick from baud_generator, one-cycle pulse, OVER_SAMPLE ticks per bit.
REQ-007 i_tx_en  input  1  enable for starting new frames.
REQ-008 i_fifo_empty  input  1  transmit FIFO empty flag.
REQ-009 i_tx_data  input  SIZE_DATA  show-ahead FIFO head word.
REQ-010 o_tx_rd  output  1  one-cycle FIFO pop.
REQ-011 o_tx_serial  output  1  serial line, idle high.
REQ-012 o_tx_busy  output  1  high while a frame is in progress.
REQ-013 o_tx_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-015 In IDLE with i_tx_en=1 and i_fifo_empty=0, the block SHALL, in the same cycle, pulse o_tx_rd, latch i_tx_data into the shift register, clear both counters, and go to START on the next edge.
REQ-016 In IDLE with i_tx_en=0 or i_fifo_empty=1, the block SHALL keep o_tx_rd=0, hold o_tx_serial=1, and stay in IDLE.
REQ-017 o_tx_serial SHALL be registered: 0 in START, shift-register bit 0 in DATA (LSB first), 1 in STOP and IDLE.
REQ-018 The tick counter SHALL increment only on i_stick=1 and SHALL clear on every state or bit change.
REQ-019 Each bit SHALL end on the i_stick at which the tick counter equals OVER_SAMPLE-1.
REQ-020 At the end of START, the block SHALL go to DATA with the bit counter at 0.
REQ-021 At the end of each DATA bit, the block SHALL shift the register right by one and increment the bit counter.
REQ-022 After bit SIZE_DATA-1, the block SHALL go to STOP.
REQ-023 At the end of STOP, the block SHALL pulse o_tx_done for one cycle and return to IDLE.
REQ-024 After STOP, a new frame SHALL be loadable in the IDLE cycle that follows, giving one idle cycle between back-to-back frames.
REQ-025 o_tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 Deasserting i_tx_en mid-frame SHALL NOT affect the current frame; it only blocks the next load.
REQ-027 i_fifo_empty and i_tx_data SHALL be ignored outside IDLE.
REQ-028 Counter widths SHALL be $clog2(OVER_SAMPLE) and $clog2(SIZE_DATA), and neither counter SHALL wrap within a state.
REQ-029 If i_stick is held high, each bit SHALL last exactly OVER_SAMPLE clock cycles.

Reset
REQ-030 While i_rst=1 at a clock edge, the block SHALL set state=IDLE, o_tx_serial=1, o_tx_rd=0, o_tx_busy=0, o_tx_done=0, and clear the counters and shift register.
REQ-031 A reset asserted mid-frame SHALL abort the frame at the next edge with no o_tx_done pulse and no o_tx_rd pulse.

Structure
REQ-032 The state enum typedef and the SIZE_DATA/OVER_SAMPLE default constants SHALL live in the shared package uart_pkg, which the Receiver also uses.
REQ-033 The block SHALL have no sub-module; baud_generator SHALL be instantiated by the parent and feed i_stick.

Verification
REQ-034 Send 0x55 with BAUDRATE_VALUE=325 -> o_tx_serial is 0,1,0,1,0,1,0,1,0,1, each level 16 sticks long, and exactly one o_tx_done pulse after 160 sticks.
REQ-035 Load 0xA5 then 0x3C back to back -> two o_tx_rd pulses, two correct frames separated by one idle cycle, and a Receiver loopback outputs 0xA5 then 0x3C.
REQ-036 i_fifo_empty=1 for 2000 cycles -> o_tx_serial=1 and o_tx_rd=0 throughout.
REQ-037 Drop i_tx_en during data bit 3 of 0xF0 with the FIFO non-empty -> the frame completes correctly, o_tx_done pulses once, and no further o_tx_rd occurs.
REQ-038 Assert i_rst for one cycle during data bit 4 -> at the next edge o_tx_serial=1 and o_tx_busy=0, with no o_tx_done; a following 0x00 frame transmits correctly.
REQ-039 Hold i_stick=1 and send 0x81 -> each bit lasts 16 clocks and o_tx_done pulses 160 clocks after START is entered.
